// File: rtl/aucohl_uart_pkg.sv
// Shared UART definitions: FSM states, parity encodings, oversampling constants.
package aucohl_uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] SAMPLE_TICK_A = 4'd7;
  localparam logic [3:0] SAMPLE_TICK_B = 4'd8;
  localparam logic [3:0] SAMPLE_TICK_C = 4'd9;
  localparam logic [3:0] LAST_TICK     = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam logic [2:0] PAR_NONE   = 3'b000;
  localparam logic [2:0] PAR_ODD    = 3'b001;
  localparam logic [2:0] PAR_EVEN   = 3'b010;
  localparam logic [2:0] PAR_STICK0 = 3'b100;
  localparam logic [2:0] PAR_STICK1 = 3'b101;

  // Unlisted codes behave as "no parity".
  function automatic logic parity_enabled(input logic [2:0] pt);
    return (pt == PAR_ODD) || (pt == PAR_EVEN) || (pt == PAR_STICK0) || (pt == PAR_STICK1);
  endfunction

  // data_xor is the XOR reduction of the data bits.
  function automatic logic parity_expected(input logic [2:0] pt, input logic data_xor);
    case (pt)
      PAR_ODD:              return ~data_xor;
      PAR_EVEN:             return data_xor;
      PAR_STICK1:           return 1'b1;
      PAR_NONE, PAR_STICK0: return 1'b0;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] clamp_size(input logic [3:0] ds);
    if (ds < 4'd5) return 4'd5;
    if (ds > 4'd9) return 4'd9;
    return ds;
  endfunction

endpackage

// File: rtl/aucohl_uart_rx_if.sv
// FIFO write port of the receiver.
// Handshake: wr is a one-cycle write strobe qualified by wdata; the receiver
// only raises wr when fifo_full was low at the frame commit, so a write is
// never issued into a full FIFO and there is no back-pressure stall.
interface aucohl_uart_rx_if #(parameter int MDW = 9);
  logic [MDW-1:0] wdata;
  logic           wr;
  logic           fifo_full;

  modport master (output wdata, output wr, input fifo_full);
  modport slave  (input wdata, input wr, output fifo_full);
endinterface

// File: rtl/aucohl_uart_bit_sampler.sv
// Tick counter within a bit (0..15) and 2-of-3 majority vote on ticks 7/8/9.
module aucohl_uart_bit_sampler
  import aucohl_uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       tick,
  input  logic       rx,
  output logic [3:0] cnt,
  output logic       maj,
  output logic       bit_q
);

  logic s_a;
  logic s_b;

  // maj is the finished vote only during tick SAMPLE_TICK_C, when rx is the third sample.
  assign maj = (s_a & s_b) | (s_a & rx) | (s_b & rx);

  // Count ticks and capture the samples; bit_q keeps the vote until the next bit.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt   <= 4'd0;
      s_a   <= 1'b1;
      s_b   <= 1'b1;
      bit_q <= 1'b1;
    end else if (tick) begin
      cnt <= cnt + 4'd1;
      if (cnt == SAMPLE_TICK_A) s_a <= rx;
      if (cnt == SAMPLE_TICK_B) s_b <= rx;
      if (cnt == SAMPLE_TICK_C) bit_q <= maj;
    end
  end

endmodule

// File: rtl/aucohl_uart_rx.sv
// UART receiver: 16x oversampled framing, parity/stop checks, break,
// overrun and idle-timeout detection, FIFO write side.
module aucohl_uart_rx
  import aucohl_uart_pkg::*;
#(
  parameter int MDW = 9,
  parameter int TW  = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          tick,
  input  logic          rx,
  input  logic [3:0]    data_size,
  input  logic [2:0]    parity_type,
  input  logic          stop_bits_count,
  input  logic [TW-1:0] timeout_bits,
  aucohl_uart_rx_if.master fifo,
  output logic          busy,
  output logic          frame_error,
  output logic          parity_error,
  output logic          break_detected,
  output logic          overrun,
  output logic          timeout,
  output uart_state_t   fsm_state
);

  uart_state_t    state, state_next;
  logic [3:0]     cnt;
  logic           maj, bit_q;
  logic           start_det, frame_end;
  logic           rx_prev;
  logic [3:0]     n_last, bit_idx;
  logic [2:0]     par_q;
  logic           par_en_q, two_q, stop_idx, stop0_q, par_bit_q;
  logic [MDW-1:0] data_q, wdata_q;
  logic           wr_q;
  logic [3:0]     idle_tick;
  logic [TW-1:0]  idle_bits;
  logic           armed;
  logic           frame_bad, all_stop_low, par_bad, is_break;

  aucohl_uart_bit_sampler u_sampler (
    .clk   (clk),
    .rst   (rst),
    .clear (state_next == ST_IDLE),
    .tick  (tick),
    .rx    (rx),
    .cnt   (cnt),
    .maj   (maj),
    .bit_q (bit_q)
  );

  // Frame outcome, evaluated on the final stop tick where maj is the last stop bit.
  assign frame_bad    = !maj || (two_q && !stop0_q);
  assign all_stop_low = !maj && (!two_q || !stop0_q);
  assign par_bad      = par_en_q && (par_bit_q != parity_expected(par_q, ^data_q));
  assign is_break     = (data_q == '0) && !(par_en_q && par_bit_q) && all_stop_low;

  assign busy       = (state != ST_IDLE);
  assign fsm_state  = state;
  assign fifo.wr    = wr_q;
  assign fifo.wdata = wdata_q;

  // Next state; a start needs rx high on an earlier tick so a held-low line cannot retrigger.
  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    frame_end  = 1'b0;
    if (!en) begin
      state_next = ST_IDLE;
    end else if (tick) begin
      unique case (state)
        ST_IDLE: if (!rx && rx_prev) begin
          start_det  = 1'b1;
          state_next = ST_START;
        end
        ST_START: if (cnt == LAST_TICK) state_next = bit_q ? ST_IDLE : ST_DATA;
        ST_DATA: if (cnt == LAST_TICK && bit_idx == n_last)
          state_next = par_en_q ? ST_PARITY : ST_STOP;
        ST_PARITY: if (cnt == LAST_TICK) state_next = ST_STOP;
        ST_STOP: if (cnt == SAMPLE_TICK_C && stop_idx == two_q) begin
          frame_end  = 1'b1;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State register, frame datapath, idle timer and registered output pulses.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state          <= ST_IDLE;
      rx_prev        <= 1'b0;
      n_last         <= 4'd4;
      par_q          <= PAR_NONE;
      par_en_q       <= 1'b0;
      two_q          <= 1'b0;
      bit_idx        <= 4'd0;
      stop_idx       <= 1'b0;
      stop0_q        <= 1'b1;
      par_bit_q      <= 1'b0;
      data_q         <= '0;
      idle_tick      <= 4'd0;
      idle_bits      <= '0;
      armed          <= 1'b0;
      wr_q           <= 1'b0;
      frame_error    <= 1'b0;
      parity_error   <= 1'b0;
      break_detected <= 1'b0;
      overrun        <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      state          <= state_next;
      wr_q           <= 1'b0;
      frame_error    <= 1'b0;
      parity_error   <= 1'b0;
      break_detected <= 1'b0;
      overrun        <= 1'b0;
      timeout        <= 1'b0;
      if (tick) rx_prev <= rx;

      if (start_det) begin
        n_last    <= clamp_size(data_size) - 4'd1;
        par_q     <= parity_type;
        par_en_q  <= parity_enabled(parity_type);
        two_q     <= stop_bits_count;
        bit_idx   <= 4'd0;
        stop_idx  <= 1'b0;
        stop0_q   <= 1'b1;
        par_bit_q <= 1'b0;
        data_q    <= '0;
      end

      if (tick && cnt == SAMPLE_TICK_C) begin
        case (state)
          ST_DATA:   data_q[bit_idx] <= maj;
          ST_PARITY: par_bit_q <= maj;
          ST_STOP:   if (!frame_end) stop0_q <= maj;
          default:   ;
        endcase
      end

      if (tick && cnt == LAST_TICK) begin
        if (state == ST_DATA) bit_idx <= bit_idx + 4'd1;
        if (state == ST_STOP) stop_idx <= 1'b1;
      end

      if (frame_end) begin
        wr_q           <= !is_break && !fifo.fifo_full;
        overrun        <= !is_break && fifo.fifo_full;
        frame_error    <= frame_bad;
        parity_error   <= par_bad && !is_break;
        break_detected <= is_break;
      end

      if (frame_end) begin
        armed     <= 1'b1;
        idle_tick <= 4'd0;
        idle_bits <= '0;
      end else if (start_det) begin
        armed     <= 1'b0;
        idle_tick <= 4'd0;
        idle_bits <= '0;
      end else if (armed && tick && state == ST_IDLE) begin
        idle_tick <= idle_tick + 4'd1;
        if (idle_tick == LAST_TICK) begin
          idle_bits <= idle_bits + TW'(1);
          if (timeout_bits != '0 && (idle_bits + TW'(1)) == timeout_bits) begin
            timeout <= 1'b1;
            armed   <= 1'b0;
          end
        end
      end
    end
  end

  // Received word; updated only when a frame is actually written.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdata_q <= '0;
    end else if (frame_end && !is_break && !fifo.fifo_full) begin
      wdata_q <= data_q;
    end
  end

endmodule

// File: tb/tb_aucohl_uart_rx.sv
// Bench for aucohl_uart_rx: directed scenarios plus random frames, scoreboard + monitor.
module tb_aucohl_uart_rx;
  import aucohl_uart_pkg::*;

  localparam int MDW = 9;
  localparam int TW  = 6;
  localparam int EW  = 32 + 1 + MDW + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          tick = 1'b0;
  logic          rx = 1'b1;
  logic [3:0]    data_size = 4'd8;
  logic [2:0]    parity_type = 3'b000;
  logic          stop_bits_count = 1'b0;
  logic [TW-1:0] timeout_bits = '0;
  logic          busy, frame_error, parity_error, break_detected, overrun, timeout;
  uart_state_t   fsm_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];
  int            to_q[$];
  logic [EW-1:0] e;

  aucohl_uart_rx_if #(.MDW(MDW)) fifo_bus ();

  aucohl_uart_rx #(.MDW(MDW), .TW(TW)) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .tick            (tick),
    .rx              (rx),
    .data_size       (data_size),
    .parity_type     (parity_type),
    .stop_bits_count (stop_bits_count),
    .timeout_bits    (timeout_bits),
    .fifo            (fifo_bus.master),
    .busy            (busy),
    .frame_error     (frame_error),
    .parity_error    (parity_error),
    .break_detected  (break_detected),
    .overrun         (overrun),
    .timeout         (timeout),
    .fsm_state       (fsm_state)
  );

  // ---------------- clock / reset / tick ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // tick = clk/4: DUT sees it on posedges where cyc becomes a multiple of 4
  always @(negedge clk) tick = (cyc % 4 == 3);

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_for(input int nbits);
    rx = 1'b1;
    repeat (64 * nbits) @(negedge clk);
  endtask

  // Wait until just after a tick edge so the next tick is bit tick 0.
  task automatic align();
    @(negedge clk);
    while (cyc % 4 != 0) @(negedge clk);
  endtask

  // Sends one frame and pushes its expected outcome; commit = cycle of the wr/flag pulse.
  task automatic send_frame(input logic [8:0] d, input logic [3:0] ds, input logic [2:0] pt,
                            input logic two, input logic flip, input logic s0, input logic s1,
                            input logic ff, input logic scramble, output int commit);
    int n;
    logic pen, pexp, psent, brk, fe, wr_e;
    logic [8:0] dm;
    logic [8:0] one9;
    logic [31:0] cc;
    logic bits[$];
    n = (ds < 5) ? 5 : ((ds > 9) ? 9 : int'(ds));
    one9 = 9'd1;
    dm = d & ((one9 << n) - 9'd1);
    pen = (pt == 3'd1) || (pt == 3'd2) || (pt == 3'd4) || (pt == 3'd5);
    case (pt)
      3'd1: pexp = ($countones(dm) % 2 == 0);
      3'd2: pexp = ($countones(dm) % 2 == 1);
      3'd5: pexp = 1'b1;
      default: pexp = 1'b0;
    endcase
    psent = pexp ^ flip;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) bits.push_back(dm[i]);
    if (pen) bits.push_back(psent);
    bits.push_back(s0);
    if (two) bits.push_back(s1);
    fe   = !s0 || (two && !s1);
    brk  = (dm == 9'd0) && (!pen || !psent) && !s0 && (!two || !s1);
    wr_e = !brk && !ff;
    data_size = ds;
    parity_type = pt;
    stop_bits_count = two;
    fifo_bus.fifo_full = ff;
    align();
    commit = cyc + 4 + 64 * (bits.size() - 1) + 36;
    cc = commit;
    exp_q.push_back({cc, wr_e, dm, fe, !brk && pen && flip, brk, !brk && ff});
    foreach (bits[i]) begin
      rx = bits[i];
      repeat (64) @(negedge clk);
      if (scramble && i == 0) begin
        data_size = 4'($urandom_range(0, 15));
        parity_type = 3'($urandom_range(0, 7));
        stop_bits_count = 1'($urandom_range(0, 1));
      end
    end
    rx = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (fifo_bus.wr || frame_error || parity_error || break_detected || overrun) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", {fifo_bus.wr, frame_error, parity_error, break_detected, overrun}, 0);
      end else begin
        e = exp_q.pop_front();
        check("commit_cycle", cyc, e[45:14]);
        check("wr", fifo_bus.wr, e[13]);
        if (e[13]) check("wdata", fifo_bus.wdata, e[12:4]);
        check("frame_error", frame_error, e[3]);
        check("parity_error", parity_error, e[2]);
        check("break_detected", break_detected, e[1]);
        check("overrun", overrun, e[0]);
      end
    end
    if (timeout) begin
      if (to_q.size() == 0) check("spurious_timeout", timeout, 0);
      else check("timeout_cycle", cyc, to_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int c, c0;
    logic [8:0] d;
    fifo_bus.fifo_full = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    check("reset_wr", fifo_bus.wr, 0);
    check("reset_wdata", fifo_bus.wdata, 0);
    check("reset_busy", busy, 0);
    check("reset_flags", {frame_error, parity_error, break_detected, overrun, timeout}, 0);
    idle_for(2);

    // 8N1 0xA5, clean
    send_frame(9'h0A5, 4'd8, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, c);
    idle_for(1);
    // 7E2 0x55 with a wrong parity bit
    send_frame(9'h055, 4'd7, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, c);
    idle_for(1);

    // break: rx low for 12 bit-times, 8N1
    data_size = 4'd8; parity_type = 3'b000; stop_bits_count = 1'b0;
    align();
    c0 = cyc;
    exp_q.push_back({32'(c0 + 4 + 64 * 9 + 36), 1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0});
    rx = 1'b0;
    repeat (12 * 64) @(negedge clk);
    idle_for(2);

    // overrun then normal write
    send_frame(9'h03C, 4'd8, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, c);
    idle_for(1);
    send_frame(9'h0C3, 4'd8, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, c);
    idle_for(1);

    // false start: low for 3 ticks only
    align();
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check("false_start_busy_high", busy, 1);
    repeat (60) @(negedge clk);
    check("false_start_back_idle", busy, 0);
    idle_for(1);

    // timeout after 4 idle bit-times, once
    timeout_bits = 6'd4;
    send_frame(9'h081, 4'd8, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, c);
    to_q.push_back(c + 256);
    idle_for(12);
    check("timeout_consumed", to_q.size(), 0);
    timeout_bits = '0;

    // reset in the middle of data bit 3 of 0xFF
    data_size = 4'd8; parity_type = 3'b000; stop_bits_count = 1'b0;
    align();
    rx = 1'b0;
    repeat (64) @(negedge clk);
    rx = 1'b1;
    repeat (64 * 3 + 32) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_wr", fifo_bus.wr, 0);
    check("midreset_wdata", fifo_bus.wdata, 0);
    check("midreset_busy", busy, 0);
    check("midreset_flags", {frame_error, parity_error, break_detected, overrun, timeout}, 0);
    repeat (64 * 6 - 33) @(negedge clk);
    idle_for(2);
    send_frame(9'h05A, 4'd8, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, c);
    idle_for(1);

    // en dropped mid-frame: frame discarded silently
    align();
    rx = 1'b0;
    repeat (64) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("en_off_busy", busy, 0);
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (64 * 8) @(negedge clk);
    idle_for(1);

    // random frames against the reference model
    for (int k = 0; k < 24; k++) begin
      logic two, flip, s0, s1, ff;
      logic [3:0] ds;
      logic [2:0] pt;
      d    = 9'($urandom_range(0, 511));
      ds   = 4'($urandom_range(4, 10));
      pt   = 3'($urandom_range(0, 7));
      two  = 1'($urandom_range(0, 1));
      flip = ($urandom_range(0, 3) == 0);
      s0   = ($urandom_range(0, 5) != 0);
      s1   = ($urandom_range(0, 5) != 0);
      ff   = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 6) == 0) begin
        d = 9'd0; s0 = 1'b0; s1 = 1'b0;
      end
      send_frame(d, ds, pt, two, flip, s0, s1, ff, 1'($urandom_range(0, 1)), c);
      idle_for(1);
    end

    // drain scoreboard with a bounded wait
    for (int w = 0; w < 2000 && exp_q.size() != 0; w++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("timeouts_drained", to_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
